// File: rtl/mux_delay_line.sv
`timescale 1ns/1ps
// Selects one of NUM_IN channels and delays it through a DEPTH-stage valid-tagged shift line.
// Latency: 1..DEPTH enabled cycles, set by the registered, clamped dly_in tap.
// Backpressure: en low stalls every stage; a flush or a delay change clears all stages.
module mux_delay_line #(
  parameter  int WIDTH  = 8,
  parameter  int NUM_IN = 4,
  parameter  int DEPTH  = 8,
  localparam int SEL_W  = $clog2(NUM_IN),
  localparam int DLY_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    flush,
  input  logic [SEL_W-1:0]        sel_in,
  input  logic [NUM_IN*WIDTH-1:0] din_flat,
  input  logic                    din_valid,
  input  logic [DLY_W-1:0]        dly_in,
  output logic [WIDTH-1:0]        q_out,
  output logic                    q_valid,
  output logic                    dly_err
);

  logic [WIDTH-1:0] sel_dat;
  logic             sel_vld;
  logic [WIDTH-1:0] cap_dat;
  logic [DLY_W-1:0] dly_d;
  logic             err_d;
  logic             dly_chg;

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [DLY_W-1:0] dly_q;
  logic             err_q;

  // Channel select; an out-of-range select yields an invalid zero sample.
  always_comb begin
    sel_dat = '0;
    sel_vld = 1'b0;
    for (int k = 0; k < NUM_IN; k++) begin
      if (int'(sel_in) == k) begin
        sel_dat = din_flat[k*WIDTH +: WIDTH];
        sel_vld = din_valid;
      end
    end
  end

  // Invalid samples enter the line as zero so every invalid stage holds zero data.
  assign cap_dat = sel_vld ? sel_dat : '0;

  // Clamp the requested delay into 1..DEPTH and flag when clamping happened.
  always_comb begin
    dly_d = dly_in;
    err_d = 1'b0;
    if (dly_in == '0) begin
      dly_d = DLY_W'(1);
      err_d = 1'b1;
    end else if (int'(dly_in) > DEPTH) begin
      dly_d = DLY_W'(DEPTH);
      err_d = 1'b1;
    end
  end

  // Moving the tap always clears, so no stale sample is ever seen at the new tap.
  assign dly_chg = (dly_d != dly_q);

  // Output tap: stage dly_q-1 drives the outputs.
  always_comb begin
    q_out   = '0;
    q_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (int'(dly_q) == i + 1) begin
        q_out   = data_q[i];
        q_valid = vld_q[i];
      end
    end
  end

  assign dly_err = err_q;

  // Delay register, clamp flag and shift line; delay change beats flush beats shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      vld_q <= '0;
      dly_q <= DLY_W'(1);
      err_q <= 1'b0;
    end else begin
      dly_q <= dly_d;
      err_q <= err_d;
      if (dly_chg || flush) begin
        for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
        vld_q <= '0;
      end else if (en) begin
        data_q[0] <= cap_dat;
        for (int i = 1; i < DEPTH; i++) data_q[i] <= data_q[i-1];
        vld_q <= {vld_q[DEPTH-2:0], sel_vld};
      end
    end
  end

endmodule

// File: tb/tb_mux_delay_line.sv
`timescale 1ns/1ps
// Directed bench for mux_delay_line with a due-time scoreboard.
// Each valid capture is queued with the enabled-edge count at which it must appear.
// Clears (flush, delay change, reset) empty the queue.
module tb_mux_delay_line;

  localparam int W = 8;
  localparam int N = 3;
  localparam int D = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         flush;
  logic [1:0]   sel_in;
  logic [N*W-1:0] din_flat;
  logic         din_valid;
  logic [3:0]   dly_in;
  logic [W-1:0] q_out;
  logic         q_valid;
  logic         dly_err;

  mux_delay_line #(.WIDTH(W), .NUM_IN(N), .DEPTH(D)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .flush     (flush),
    .sel_in    (sel_in),
    .din_flat  (din_flat),
    .din_valid (din_valid),
    .dly_in    (dly_in),
    .q_out     (q_out),
    .q_valid   (q_valid),
    .dly_err   (dly_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   en_cnt = 0;
  int   dly_m  = 1;
  logic err_m  = 1'b0;
  int   step_n = 0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
    n_cmp++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, want);
    end
  endtask

  task automatic check_out(input string tag);
    logic [W-1:0] ed;
    logic         ev;
    while (sb.size() > 0 && sb[0].due < en_cnt) void'(sb.pop_front());
    ed = '0;
    ev = 1'b0;
    if (sb.size() > 0 && sb[0].due == en_cnt) begin
      ed = sb[0].d;
      ev = 1'b1;
    end
    chk({tag, " q_out"},   q_out, ed);
    chk({tag, " q_valid"}, {7'b0, q_valid}, {7'b0, ev});
    chk({tag, " dly_err"}, {7'b0, dly_err}, {7'b0, err_m});
  endtask

  task automatic step(input string tag, input logic e, input logic f, input logic [1:0] s,
                      input logic [W-1:0] d, input logic v, input logic [3:0] dl);
    int   si;
    int   c;
    logic fl;
    si        = int'(s);
    en        = e;
    flush     = f;
    sel_in    = s;
    din_valid = v;
    dly_in    = dl;
    din_flat  = 24'($urandom());
    if (si < N) din_flat[si*W +: W] = d;
    @(posedge clk);
    #1;
    fl = (dl == 4'd0) || (int'(dl) > D);
    c  = (dl == 4'd0) ? 1 : ((int'(dl) > D) ? D : int'(dl));
    err_m = fl;
    if (c != dly_m) begin
      sb.delete();
      dly_m = c;
    end else if (f) begin
      sb.delete();
    end else if (e) begin
      en_cnt++;
      if (v && si < N) sb.push_back('{d, en_cnt + dly_m - 1});
    end
    step_n++;
    check_out($sformatf("%s#%0d", tag, step_n));
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; flush = 1'b0; sel_in = '0;
    din_valid = 1'b0; din_flat = '0; dly_in = 4'd1;
    #1;
    check_out("reset");
    #1 rst = 1'b1;

    // Basic delay of 3 on channel 2
    step("basic", 1, 0, 2, 8'h00, 0, 3);
    for (int i = 0; i < 3; i++) step("basic", 1, 0, 2, 8'h00, 0, 3);
    step("basic", 1, 0, 2, 8'hA5, 1, 3);
    for (int i = 0; i < 5; i++) step("basic", 1, 0, 2, 8'h00, 0, 3);

    // Stall with delay 4: sample must wait for enabled edges only
    step("stall", 1, 0, 0, 8'h00, 0, 4);
    step("stall", 1, 0, 1, 8'h3C, 1, 4);
    step("stall", 1, 0, 0, 8'h00, 0, 4);
    for (int i = 0; i < 5; i++) step("stall", 0, 0, 1, 8'hFF, 1, 4);
    for (int i = 0; i < 5; i++) step("stall", 1, 0, 0, 8'h00, 0, 4);

    // Stream at delay 2, then clamped change to 9 (effective 8), then 0 (effective 1)
    for (int i = 1; i <= 6; i++) step("stream2", 1, 0, 0, 8'(i), 1, 2);
    for (int i = 7; i <= 18; i++) step("clamp9", 1, 0, 0, 8'(i), 1, 9);
    for (int i = 19; i <= 22; i++) step("clamp0", 1, 0, 1, 8'(i), 1, 0);

    // Flush with en high: pipeline cleared, presented sample dropped
    for (int i = 0; i < 5; i++) step("preflush", 1, 0, 2, 8'(8'h40 + i), 1, 3);
    step("flush", 1, 1, 2, 8'h77, 1, 3);
    for (int i = 0; i < 4; i++) step("postflush", 1, 0, 2, 8'(8'h50 + i), 1, 3);

    // Out-of-range select at delay 1
    step("badsel", 1, 0, 3, 8'h99, 1, 1);
    step("badsel", 1, 0, 3, 8'h99, 1, 1);
    step("goodsel", 1, 0, 0, 8'h5A, 1, 1);
    step("badsel", 1, 0, 3, 8'h99, 1, 1);

    // Async reset between edges with the line full
    for (int i = 0; i < 7; i++) step("fill5", 1, 0, 1, 8'(8'hC0 + i), 1, 5);
    #2 rst = 1'b0;
    #1;
    sb.delete();
    dly_m = 1;
    err_m = 1'b0;
    check_out("async_rst");
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) step("post_rst", 1, 0, 1, 8'(8'hE0 + i), 1, 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mux_delay_line.md
Name: mux_delay_line

Overview:
Parametrised successor to the team's single-bit select-and-delay flop. The block selects one of NUM_IN data channels, each WIDTH bits wide. It delays the selected sample through a DEPTH-stage shift register with a runtime-programmable tap, so latency is 1..DEPTH enabled cycles. Each stage carries a valid bit. Stall (en), flush and delay-change handling make it usable as a configurable alignment/delay element in datapaths.

Parameters:
WIDTH, 8, data width per channel
NUM_IN, 4, number of input channels (>=2; need not be a power of two)
DEPTH, 8, maximum delay in enabled cycles (>=2)
SEL_W, $clog2(NUM_IN), select width (derived localparam, not overridable)
DLY_W, $clog2(DEPTH+1), delay-control width (derived localparam, not overridable)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous, active-low reset
en  input  1  shift enable; low = stall, all state held
flush  input  1  synchronous clear of all stages
sel_in  input  SEL_W  channel select
din_flat  input  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
din_valid  input  1  qualifies the selected channel this cycle
dly_in  input  DLY_W  requested delay, legal range 1..DEPTH
q_out  output  WIDTH  delayed data
q_valid  output  1  q_out holds a valid sample
dly_err  output  1  registered; high while the applied delay was clamped

Behaviour:
- Select (combinational): sel_in < NUM_IN -> sel_data = channel sel_in, sel_vld = din_valid. sel_in >= NUM_IN -> sel_data = 0, sel_vld = 0.
- Stage-0 capture value is sel_vld ? sel_data : 0. Invalid stages always hold data 0.
- Delay clamp (combinational): dly_in = 0 -> 1; dly_in > DEPTH -> DEPTH; otherwise dly_in. The clamp flag is true whenever clamping occurred.
- dly_reg <= clamped value every clock, independent of en. dly_err <= clamp flag every clock.
- Outputs (combinational from registers): q_out = stage[dly_reg-1].data, q_valid = stage[dly_reg-1].valid.
- Latency: a sample captured at edge N appears on q_out after dly_reg enabled edges, counting edge N as the first. With dly_reg=1, the sample is visible right after edge N, which is the legacy one-cycle flop behaviour.
- Per-edge priority, highest first:
  1. rst low (async): all stage data/valid = 0, dly_reg = 1, dly_err = 0.
  2. delay change (clamped value != dly_reg): all stages cleared (data 0, valid 0); no capture; dly_reg takes the new value.
  3. flush: all stages cleared; no capture.
  4. en: stage[0] <= capture value; stage[i] <= stage[i-1] for i = 1..DEPTH-1.
  5. otherwise: hold.
- After any clear, q_valid stays 0 until a valid sample has travelled dly_reg enabled cycles. There are no duplicated or stale samples across a delay change.
- Reset mid-operation: outputs go to 0 immediately (asynchronous). The first capture is allowed on the first edge after rst deasserts.
- Stages beyond dly_reg-1 keep shifting but are not observed. The tap moves only via a delay change, which always clears.
- Reset values: q_out = 0, q_valid = 0, dly_err = 0.

Test Plan:
- Basic delay: WIDTH=8, NUM_IN=4, DEPTH=8, dly_in=3, en=1, sel_in=2, channel 2 = 0xA5, din_valid=1 for one cycle captured at edge 10 -> q_out=0xA5, q_valid=1 after edge 12 only; 0/0 otherwise.
- Stall: dly_in=4, sample 0x3C captured, en dropped for 5 cycles after the second edge -> q_out=0x3C appears after 4 enabled edges (9 edges total); q_out/q_valid stable during the stall.
- Delay change and clamp: stream 0x01,0x02,... with dly_in=2, then dly_in switched to 9 -> all valid cleared, dly_err=1, effective delay 8, first q_valid 8 enabled edges later. dly_in=0 -> delay 1, dly_err=1.
- Flush vs en: flush=1 and en=1 with pipeline full -> q_valid=0 next cycle; sample presented that cycle is not captured.
- Illegal select: NUM_IN=3, sel_in=3, din_valid=1, dly_in=1 -> q_valid=0, q_out=0 after the next edge.
- Async reset: rst driven low between edges with pipeline full -> q_out=0, q_valid=0 immediately, no clock required; after release, dly_reg=1 unless dly_in differs (then a clear occurs on the first edge).
